// File: rtl/uart_alu_intf.sv
// Frames three received bytes (A, B, opcode) into registered ALU operands and
// returns the captured ALU result to the UART transmitter with a start pulse.
module uart_alu_intf #(
   parameter int DBIT        = 8,
   parameter int NB_OP       = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_done_tick,
   input  logic [DBIT-1:0]  rx_data,
   input  logic [DBIT-1:0]  alu_result,
   input  logic             tx_done_tick,
   output logic [DBIT-1:0]  alu_a,
   output logic [DBIT-1:0]  alu_b,
   output logic [NB_OP-1:0] alu_op,
   output logic             tx_start,
   output logic [DBIT-1:0]  tx_data,
   output logic             busy,
   output logic             err_timeout,
   output logic             rx_drop
);

   // state  | meaning
   // S_A    | waiting for operand A (idle)
   // S_B    | waiting for operand B, inter-byte timer running
   // S_OP   | waiting for opcode, inter-byte timer running
   // S_EXEC | operands stable, ALU result settling; capture it
   // S_TX   | result handed to transmitter, waiting for tx_done_tick
   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_TX   = 3'd4
   } state_t;

   localparam bit            TO_EN    = (TIMEOUT_CYC > 0);
   localparam int            CW       = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT_CYC - 1 : 0);

   state_t             state_q;
   logic [DBIT-1:0]    a_q;
   logic [DBIT-1:0]    b_q;
   logic [NB_OP-1:0]   op_q;
   logic [DBIT-1:0]    txd_q;
   logic               tx_start_q;
   logic               busy_q;
   logic               err_q;
   logic               drop_q;
   logic [CW-1:0]      cnt_q;
   logic [CW-1:0]      cnt_d;
   logic               timeout_hit;

   assign cnt_d       = cnt_q + CW'(1);
   assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         txd_q      <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= 1'b0;
         case (state_q)
            S_A: begin
               if (rx_done_tick) begin
                  a_q     <= rx_data;
                  cnt_q   <= '0;
                  state_q <= S_B;
               end
            end
            S_B: begin
               // An arriving byte takes priority over the terminal timeout cycle.
               if (rx_done_tick) begin
                  b_q     <= rx_data;
                  cnt_q   <= '0;
                  state_q <= S_OP;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_A;
               end else if (TO_EN) begin
                  cnt_q   <= cnt_d;
               end
            end
            S_OP: begin
               if (rx_done_tick) begin
                  op_q    <= rx_data[NB_OP-1:0];
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_EXEC;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_A;
               end else if (TO_EN) begin
                  cnt_q   <= cnt_d;
               end
            end
            S_EXEC: begin
               txd_q      <= alu_result;
               tx_start_q <= 1'b1;
               drop_q     <= rx_done_tick;
               state_q    <= S_TX;
            end
            S_TX: begin
               drop_q <= rx_done_tick;
               if (tx_done_tick) begin
                  busy_q  <= 1'b0;
                  state_q <= S_A;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_A;
            end
         endcase
      end
   end

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_op      = op_q;
   assign tx_data     = txd_q;
   assign tx_start    = tx_start_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign rx_drop     = drop_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf: one instance with a 100-cycle timeout and one with
// the timeout disabled, each driving a behavioural ALU from its operand outputs.
module tb_uart_alu_intf;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_tick, tx_done;
   logic [7:0] rx_data;
   logic [7:0] alu_res, alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, busy, err_to, rx_drop;

   logic       rx0_tick, tx0_done;
   logic [7:0] rx0_data;
   logic [7:0] alu_res0, alu_a0, alu_b0, tx_data0;
   logic [5:0] alu_op0;
   logic       tx_start0, busy0, err_to0, rx_drop0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h03:   return 8'($signed(a) >>> b);
         6'h02:   return a >> b;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_res  = alu_f(alu_a, alu_b, alu_op);
   assign alu_res0 = alu_f(alu_a0, alu_b0, alu_op0);

   uart_alu_intf #(.DBIT(8), .NB_OP(6), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_tick), .rx_data(rx_data),
      .alu_result(alu_res), .tx_done_tick(tx_done), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
      .err_timeout(err_to), .rx_drop(rx_drop));

   uart_alu_intf #(.DBIT(8), .NB_OP(6), .TIMEOUT_CYC(0)) dut0 (
      .clk(clk), .reset(reset), .rx_done_tick(rx0_tick), .rx_data(rx0_data),
      .alu_result(alu_res0), .tx_done_tick(tx0_done), .alu_a(alu_a0), .alu_b(alu_b0),
      .alu_op(alu_op0), .tx_start(tx_start0), .tx_data(tx_data0), .busy(busy0),
      .err_timeout(err_to0), .rx_drop(rx_drop0));

   // Drive a byte at a falling edge; it is taken at the next rising edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [7:0] exp, input int gap, input bit do_done);
      send_byte(a);
      idle(gap);
      send_byte(b);
      idle(gap);
      send_byte(opb);
      if ({alu_a, alu_b, alu_op} !== {a, b, opb[5:0]}) begin
         n_bad++;
         $display("FAIL frame_operands: got %h/%h/%h want %h/%h/%h",
                  alu_a, alu_b, alu_op, a, b, opb[5:0]);
      end
      n_cmp++;
      if ({busy, tx_start} !== 2'b10) begin
         n_bad++;
         $display("FAIL frame_exec_flags: busy,tx_start got %b want 10", {busy, tx_start});
      end
      n_cmp++;
      @(negedge clk);
      if ({tx_start, tx_data} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL frame_tx_start: got start=%b data=%h want start=1 data=%h",
                  tx_start, tx_data, exp);
      end
      n_cmp++;
      @(negedge clk);
      if ({tx_start, busy} !== 2'b01) begin
         n_bad++;
         $display("FAIL frame_pulse_width: tx_start,busy got %b want 01", {tx_start, busy});
      end
      n_cmp++;
      if (do_done) begin
         idle($urandom_range(0, 5));
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         if ({busy, tx_data} !== {1'b0, exp}) begin
            n_bad++;
            $display("FAIL frame_done: got busy=%b data=%h want busy=0 data=%h",
                     busy, tx_data, exp);
         end
         n_cmp++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_to, rx_drop} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_to, rx_drop});
      end
      n_cmp++;
      if ({alu_a0, alu_b0, alu_op0, tx_data0, tx_start0, busy0, err_to0, rx_drop0} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs_t0: got %h want 0",
                  {alu_a0, alu_b0, alu_op0, tx_data0, tx_start0, busy0, err_to0, rx_drop0});
      end
      n_cmp++;
   endtask

   task automatic test_basic_add;
      run_frame(8'h05, 8'h03, 8'h20, 8'h08, 2, 1'b1);
   endtask

   task automatic test_timeout;
      logic seen_early;
      seen_early = 1'b0;
      send_byte(8'h11);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i < 100 && err_to) seen_early = 1'b1;
      end
      if ({seen_early, err_to, alu_a} !== {1'b0, 1'b1, 8'h11}) begin
         n_bad++;
         $display("FAIL timeout_b: early=%b err=%b a=%h want early=0 err=1 a=11",
                  seen_early, err_to, alu_a);
      end
      n_cmp++;
      @(negedge clk);
      if (err_to !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_pulse: err got %b want 0", err_to);
      end
      n_cmp++;
      run_frame(8'h02, 8'h01, 8'h22, 8'h01, 1, 1'b1);
      send_byte(8'h7C);
      send_byte(8'h3D);
      idle(99);
      if (err_to !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_op_early: err got %b want 0", err_to);
      end
      n_cmp++;
      @(negedge clk);
      if ({err_to, busy, alu_a, alu_b} !== {1'b1, 1'b0, 8'h7C, 8'h3D}) begin
         n_bad++;
         $display("FAIL timeout_op: got err=%b busy=%b a=%h b=%h want 1 0 7c 3d",
                  err_to, busy, alu_a, alu_b);
      end
      n_cmp++;
   endtask

   task automatic test_drop;
      run_frame(8'h40, 8'h04, 8'h02, 8'h04, 0, 1'b0);
      send_byte(8'hAA);
      if ({rx_drop, busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL drop_in_tx: rx_drop,busy got %b want 11", {rx_drop, busy});
      end
      n_cmp++;
      @(negedge clk);
      if (rx_drop !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_pulse: rx_drop got %b want 0", rx_drop);
      end
      n_cmp++;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF, 3, 1'b1);
   endtask

   task automatic test_reset_midframe;
      send_byte(8'h77);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_to, rx_drop} !== '0) begin
         n_bad++;
         $display("FAIL reset_midframe: got %h want 0",
                  {alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_to, rx_drop});
      end
      n_cmp++;
      run_frame(8'h06, 8'h03, 8'h24, 8'h02, 1, 1'b1);
   endtask

   task automatic test_terminal_cycle;
      send_byte(8'h31);
      idle(99);
      send_byte(8'h32);
      if ({err_to, alu_b} !== {1'b0, 8'h32}) begin
         n_bad++;
         $display("FAIL terminal_b: err=%b b=%h want err=0 b=32", err_to, alu_b);
      end
      n_cmp++;
      idle(99);
      send_byte(8'h20);
      if ({err_to, busy, alu_op} !== {1'b0, 1'b1, 6'h20}) begin
         n_bad++;
         $display("FAIL terminal_op: err=%b busy=%b op=%h want 0 1 20", err_to, busy, alu_op);
      end
      n_cmp++;
      @(negedge clk);
      if ({tx_start, tx_data} !== {1'b1, 8'h63}) begin
         n_bad++;
         $display("FAIL terminal_tx: start=%b data=%h want 1 63", tx_start, tx_data);
      end
      n_cmp++;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic test_coincident;
      run_frame(8'h09, 8'h0C, 8'h26, 8'h05, 0, 1'b0);
      rx_data  = 8'h5A;
      rx_tick  = 1'b1;
      tx_done  = 1'b1;
      @(negedge clk);
      rx_tick  = 1'b0;
      tx_done  = 1'b0;
      if ({rx_drop, busy, alu_a} !== {1'b1, 1'b0, 8'h09}) begin
         n_bad++;
         $display("FAIL coincident: drop=%b busy=%b a=%h want 1 0 09", rx_drop, busy, alu_a);
      end
      n_cmp++;
      run_frame(8'h81, 8'h01, 8'h03, 8'hC0, 0, 1'b1);
   endtask

   task automatic test_random_frames;
      logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
      logic [7:0] a, b, opb;
      for (int i = 0; i < 24; i++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         opb = {2'($urandom), ops[$urandom_range(0, 7)]};
         if ((i % 3) == 0) begin
            run_frame(a, b, opb, alu_f(a, b, opb[5:0]), $urandom_range(0, 40), 1'b0);
            send_byte(8'($urandom));
            if (rx_drop !== 1'b1) begin
               n_bad++;
               $display("FAIL rand_drop[%0d]: rx_drop got %b want 1", i, rx_drop);
            end
            n_cmp++;
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end else begin
            run_frame(a, b, opb, alu_f(a, b, opb[5:0]), $urandom_range(0, 40), 1'b1);
         end
      end
   endtask

   task automatic test_timeout_disabled;
      logic seen;
      seen = 1'b0;
      rx0_data = 8'h44;
      rx0_tick = 1'b1;
      @(negedge clk);
      rx0_tick = 1'b0;
      repeat (10000) begin
         @(negedge clk);
         if (err_to0) seen = 1'b1;
      end
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL t0_no_timeout: err seen %b want 0", seen);
      end
      n_cmp++;
      rx0_data = 8'h55;
      rx0_tick = 1'b1;
      @(negedge clk);
      rx0_data = 8'h26;
      @(negedge clk);
      rx0_tick = 1'b0;
      if ({alu_a0, alu_b0, alu_op0, busy0} !== {8'h44, 8'h55, 6'h26, 1'b1}) begin
         n_bad++;
         $display("FAIL t0_still_in_b: got %h/%h/%h busy=%b want 44/55/26 busy=1",
                  alu_a0, alu_b0, alu_op0, busy0);
      end
      n_cmp++;
      @(negedge clk);
      if ({tx_start0, tx_data0} !== {1'b1, 8'h11}) begin
         n_bad++;
         $display("FAIL t0_tx: start=%b data=%h want 1 11", tx_start0, tx_data0);
      end
      n_cmp++;
   endtask

   initial begin
      reset    = 1'b1;
      rx_tick  = 1'b0;
      rx_data  = 8'h00;
      tx_done  = 1'b0;
      rx0_tick = 1'b0;
      rx0_data = 8'h00;
      tx0_done = 1'b0;
      @(negedge clk);
      test_reset;
      test_basic_add;
      test_timeout;
      test_drop;
      test_reset_midframe;
      test_terminal_cycle;
      test_coincident;
      test_random_frames;
      test_timeout_disabled;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
